// File: rtl/fb_window_reader.sv
// Purpose: scans a frame one window at a time, fetching each 5-row x 20-bit chunk from the framebuffer and presenting it downstream.
// Latency: 3 cycles per window minimum (ISSUE, RELEASE, OUTPUT) given immediate framebuffer ready edges and win_ready=1.
// Backpressure: win_valid holds the captured window until win_ready; no new framebuffer read is issued during a stall.
module fb_window_reader #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int X_STEP  = 1,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic        err,
    output logic [9:0]  fb_x_pos,
    output logic [9:0]  fb_y_pos,
    output logic        fb_read,
    input  logic [99:0] fb_data_chunk,
    input  logic        fb_data_ready,
    output logic [99:0] win_data,
    output logic [9:0]  win_x,
    output logic [9:0]  win_y,
    output logic        win_valid,
    input  logic        win_ready,
    output logic        win_last
);

    // Counter only needs to reach TIMEOUT-1; the timeout fires on the edge where it is already there.
    localparam int              CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [10:0]     WIDTH_11 = 11'(WIDTH);
    localparam logic [10:0]     STEP_11  = 11'(X_STEP);
    localparam logic [9:0]      Y_LAST   = 10'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RELEASE = 2'd2,
        S_OUTPUT  = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [9:0]      r_x;
    logic [9:0]      r_y;
    logic            r_fb_read;
    logic            r_busy;
    logic            r_frame_done;
    logic            r_err;
    logic            r_win_valid;
    logic            r_win_last;
    logic [9:0]      r_win_x;
    logic [9:0]      r_win_y;
    logic [99:0]     r_win_data;

    // Next column is computed in 11 bits so x+X_STEP can never wrap past WIDTH unnoticed.
    logic [10:0]     w_x_next;
    logic            w_row_end;
    logic            w_last_win;
    logic            w_cnt_exp;

    assign w_x_next   = {1'b0, r_x} + STEP_11;
    assign w_row_end  = (w_x_next >= WIDTH_11);
    assign w_last_win = w_row_end && (r_y == Y_LAST);
    assign w_cnt_exp  = (r_cnt == CNT_LAST);

    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign err        = r_err;
    assign fb_x_pos   = r_x;
    assign fb_y_pos   = r_y;
    assign fb_read    = r_fb_read;
    assign win_data   = r_win_data;
    assign win_x      = r_win_x;
    assign win_y      = r_win_y;
    assign win_valid  = r_win_valid;
    assign win_last   = r_win_last;

    // Scan sequencer: all outputs are registered and updated alongside the state transition that implies them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_fb_read    <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
            r_win_valid  <= 1'b0;
            r_win_last   <= 1'b0;
            r_win_x      <= '0;
            r_win_y      <= '0;
            r_win_data   <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x       <= '0;
                        r_y       <= '0;
                        r_err     <= 1'b0;
                        r_cnt     <= '0;
                        r_fb_read <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (fb_data_ready) begin
                        r_win_data <= fb_data_chunk;
                        r_win_x    <= r_x;
                        r_win_y    <= r_y;
                        r_win_last <= w_last_win;
                        r_fb_read  <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= S_RELEASE;
                    end else if (w_cnt_exp) begin
                        r_err     <= 1'b1;
                        r_fb_read <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!fb_data_ready) begin
                        r_win_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_OUTPUT;
                    end else if (w_cnt_exp) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (win_ready) begin
                        r_win_valid <= 1'b0;
                        r_win_last  <= 1'b0;
                        r_cnt       <= '0;
                        if (w_last_win) begin
                            r_frame_done <= 1'b1;
                            r_busy       <= 1'b0;
                            r_state      <= S_IDLE;
                        end else begin
                            if (w_row_end) begin
                                r_x <= '0;
                                r_y <= r_y + 10'd1;
                            end else begin
                                r_x <= w_x_next[9:0];
                            end
                            r_fb_read <= 1'b1;
                            r_state   <= S_ISSUE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_window_reader.sv
// Purpose: directed bench for fb_window_reader; dut1 is 4x3 step 1, dut2 is 4x3 step 3.
// Latency: expects 3 cycles per window with the responsive framebuffer model below.
// Backpressure: stalls win_ready on window (2,1) and checks the window is held with no new read.
module tb_fb_window_reader;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        last;
        logic [99:0] d;
    } rec_t;

    logic clk;
    logic reset;

    logic        start1, busy1, frame_done1, err1, fb_read1, fb_data_ready1;
    logic        win_valid1, win_ready1, win_last1;
    logic [9:0]  fb_x_pos1, fb_y_pos1, win_x1, win_y1;
    logic [99:0] fb_data_chunk1, win_data1;

    logic        start2, busy2, frame_done2, err2, fb_read2, fb_data_ready2;
    logic        win_valid2, win_ready2, win_last2;
    logic [9:0]  fb_x_pos2, fb_y_pos2, win_x2, win_y2;
    logic [99:0] fb_data_chunk2, win_data2;

    int   total;
    int   bad;
    int   fd1;
    int   fd2;
    bit   m1_en;
    rec_t q1[$];
    rec_t q2[$];

    logic [79:0]  tag_c;
    logic [99:0]  garb_c;

    fb_window_reader #(.WIDTH(4), .HEIGHT(3), .X_STEP(1), .TIMEOUT(15)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .frame_done(frame_done1),
        .err(err1), .fb_x_pos(fb_x_pos1), .fb_y_pos(fb_y_pos1), .fb_read(fb_read1),
        .fb_data_chunk(fb_data_chunk1), .fb_data_ready(fb_data_ready1), .win_data(win_data1),
        .win_x(win_x1), .win_y(win_y1), .win_valid(win_valid1), .win_ready(win_ready1),
        .win_last(win_last1)
    );

    fb_window_reader #(.WIDTH(4), .HEIGHT(3), .X_STEP(3), .TIMEOUT(15)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .busy(busy2), .frame_done(frame_done2),
        .err(err2), .fb_x_pos(fb_x_pos2), .fb_y_pos(fb_y_pos2), .fb_read(fb_read2),
        .fb_data_chunk(fb_data_chunk2), .fb_data_ready(fb_data_ready2), .win_data(win_data2),
        .win_x(win_x2), .win_y(win_y2), .win_valid(win_valid2), .win_ready(win_ready2),
        .win_last(win_last2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [99:0] exp_chunk(input int x, input int y);
        logic [9:0] xv;
        logic [9:0] yv;
        xv = 10'(x);
        yv = 10'(y);
        return {yv, xv, 80'h5A5A_0F0F_1234_5678_9ABC};
    endfunction

    // Framebuffer model: ready rises one cycle after read, falls one cycle after read drops.
    always @(negedge clk) begin
        fb_data_ready1 = m1_en & fb_read1;
        fb_data_chunk1 = fb_data_ready1 ? {fb_y_pos1, fb_x_pos1, tag_c} : garb_c;
        fb_data_ready2 = fb_read2;
        fb_data_chunk2 = fb_data_ready2 ? {fb_y_pos2, fb_x_pos2, tag_c} : garb_c;
    end

    // Record every downstream handshake and frame_done cycle.
    always @(negedge clk) begin
        rec_t r;
        #1;
        if (win_valid1 && win_ready1) begin
            r.x = win_x1; r.y = win_y1; r.last = win_last1; r.d = win_data1;
            q1.push_back(r);
        end
        if (win_valid2 && win_ready2) begin
            r.x = win_x2; r.y = win_y2; r.last = win_last2; r.d = win_data2;
            q2.push_back(r);
        end
        if (frame_done1) fd1++;
        if (frame_done2) fd2++;
    end

    task automatic run_scan(input bit sel, input bit poke, output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = -1;
        @(negedge clk);
        if (sel) start2 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #2;
            if (sel ? frame_done2 : frame_done1) begin
                ok  = 1'b1;
                cyc = i;
                break;
            end
            start1 = (poke && (i == 4 || i == 11 || i == 20)) ? 1'b1 : 1'b0;
        end
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        #2;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy1, frame_done1, err1, fb_read1, win_valid1, win_last1, fb_x_pos1, fb_y_pos1,
             win_x1, win_y1, win_data1} !== '0) begin
            bad++;
            $display("FAIL reset_state1 got busy=%b fd=%b err=%b rd=%b vld=%b last=%b data=%h want all 0",
                     busy1, frame_done1, err1, fb_read1, win_valid1, win_last1, win_data1);
        end
        total++;
        if ({busy2, frame_done2, err2, fb_read2, win_valid2, win_last2, fb_x_pos2, fb_y_pos2,
             win_x2, win_y2, win_data2} !== '0) begin
            bad++;
            $display("FAIL reset_state2 got busy=%b vld=%b rd=%b want all 0", busy2, win_valid2, fb_read2);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_scan;
        bit ok;
        int cyc;
        rec_t e;
        q1.delete();
        fd1 = 0;
        run_scan(1'b0, 1'b0, ok, cyc);
        total++;
        if (!ok) begin bad++; $display("FAIL full_done got no frame_done want pulse"); end
        total++;
        if (cyc !== 35) begin bad++; $display("FAIL full_throughput got %0d want 35", cyc); end
        total++;
        if (q1.size() !== 12) begin bad++; $display("FAIL full_count got %0d want 12", q1.size()); end
        for (int i = 0; i < 12 && i < q1.size(); i++) begin
            e.x = 10'(i % 4); e.y = 10'(i / 4); e.last = (i == 11); e.d = exp_chunk(i % 4, i / 4);
            total++;
            if (q1[i] !== e) begin
                bad++;
                $display("FAIL full_win[%0d] got x=%0d y=%0d last=%b d=%h want x=%0d y=%0d last=%b d=%h",
                         i, q1[i].x, q1[i].y, q1[i].last, q1[i].d, e.x, e.y, e.last, e.d);
            end
        end
        total++;
        if (fd1 !== 1) begin bad++; $display("FAIL full_fd_pulses got %0d want 1", fd1); end
        total++;
        if ({busy1, err1, win_valid1} !== 3'b000) begin
            bad++; $display("FAIL full_idle got busy=%b err=%b vld=%b want 000", busy1, err1, win_valid1);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        int cyc;
        bit seen;
        q1.delete();
        fd1 = 0;
        fork
            run_scan(1'b0, 1'b0, ok, cyc);
            begin
                seen = 1'b0;
                for (int i = 0; i < 200 && !seen; i++) begin
                    @(negedge clk);
                    if (win_valid1 && win_x1 == 10'd2 && win_y1 == 10'd1) seen = 1'b1;
                end
                total++;
                if (!seen) begin bad++; $display("FAIL bp_reach got no window (2,1) want it"); end
                if (seen) begin
                    win_ready1 = 1'b0;
                    for (int k = 0; k < 5; k++) begin
                        @(negedge clk);
                        total++;
                        if ({win_valid1, fb_read1, win_x1, win_y1, win_data1} !==
                            {1'b1, 1'b0, 10'd2, 10'd1, exp_chunk(2, 1)}) begin
                            bad++;
                            $display("FAIL bp_hold[%0d] got vld=%b rd=%b x=%0d y=%0d d=%h want vld=1 rd=0 x=2 y=1 d=%h",
                                     k, win_valid1, fb_read1, win_x1, win_y1, win_data1, exp_chunk(2, 1));
                        end
                    end
                    win_ready1 = 1'b1;
                end
            end
        join
        total++;
        if (!ok || q1.size() !== 12) begin
            bad++; $display("FAIL bp_scan got ok=%b count=%0d want 1/12", ok, q1.size());
        end
        total++;
        if (cyc !== 40) begin bad++; $display("FAIL bp_cycles got %0d want 40", cyc); end
        if (q1.size() == 12) begin
            total++;
            if ({q1[6].x, q1[6].y, q1[7].x, q1[7].y} !== {10'd2, 10'd1, 10'd3, 10'd1}) begin
                bad++; $display("FAIL bp_order got (%0d,%0d)(%0d,%0d) want (2,1)(3,1)",
                                q1[6].x, q1[6].y, q1[7].x, q1[7].y);
            end
        end
    endtask

    task automatic test_xstep;
        bit ok;
        int cyc;
        rec_t e;
        q2.delete();
        fd2 = 0;
        run_scan(1'b1, 1'b0, ok, cyc);
        total++;
        if (!ok || cyc !== 17) begin bad++; $display("FAIL xstep_done got ok=%b cyc=%0d want 1/17", ok, cyc); end
        total++;
        if (q2.size() !== 6) begin bad++; $display("FAIL xstep_count got %0d want 6", q2.size()); end
        for (int i = 0; i < 6 && i < q2.size(); i++) begin
            e.x = 10'((i % 2) * 3); e.y = 10'(i / 2); e.last = (i == 5); e.d = exp_chunk((i % 2) * 3, i / 2);
            total++;
            if (q2[i] !== e) begin
                bad++;
                $display("FAIL xstep_win[%0d] got x=%0d y=%0d last=%b want x=%0d y=%0d last=%b",
                         i, q2[i].x, q2[i].y, q2[i].last, e.x, e.y, e.last);
            end
        end
        total++;
        if (fd2 !== 1) begin bad++; $display("FAIL xstep_fd got %0d want 1", fd2); end
    endtask

    task automatic test_timeout;
        bit ok;
        int cyc;
        bit early;
        m1_en = 1'b0;
        fd1 = 0;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        total++;
        if ({busy1, fb_read1} !== 2'b11) begin
            bad++; $display("FAIL to_issue got busy=%b rd=%b want 11", busy1, fb_read1);
        end
        early = 1'b0;
        for (int k = 1; k < 15; k++) begin
            @(negedge clk);
            if (err1 || !fb_read1) early = 1'b1;
        end
        total++;
        if (early) begin bad++; $display("FAIL to_early got err before 15 cycles want none"); end
        @(negedge clk);
        total++;
        if ({err1, fb_read1, busy1} !== 3'b100) begin
            bad++; $display("FAIL to_fire got err=%b rd=%b busy=%b want 100", err1, fb_read1, busy1);
        end
        repeat (2) @(negedge clk);
        total++;
        if (fd1 !== 0 || err1 !== 1'b1) begin
            bad++; $display("FAIL to_sticky got fd=%0d err=%b want 0/1", fd1, err1);
        end
        m1_en = 1'b1;
        q1.delete();
        run_scan(1'b0, 1'b0, ok, cyc);
        total++;
        if (!ok || err1 !== 1'b0 || q1.size() !== 12) begin
            bad++; $display("FAIL to_restart got ok=%b err=%b count=%0d want 1/0/12", ok, err1, q1.size());
        end
    endtask

    task automatic test_reset_midscan;
        bit ok;
        bit seen;
        int cyc;
        fd1 = 0;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (win_valid1 && win_x1 == 10'd1 && win_y1 == 10'd1) seen = 1'b1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL rst_reach got no window (1,1) want it"); end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({busy1, frame_done1, err1, fb_read1, win_valid1, win_last1, fb_x_pos1, fb_y_pos1,
             win_x1, win_y1, win_data1} !== '0) begin
            bad++;
            $display("FAIL rst_async got busy=%b vld=%b x=%0d y=%0d d=%h want all 0",
                     busy1, win_valid1, win_x1, win_y1, win_data1);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if ({busy1, fb_read1, win_valid1} !== 3'b000 || fd1 !== 0) begin
            bad++; $display("FAIL rst_idle got busy=%b rd=%b vld=%b fd=%0d want 000/0", busy1, fb_read1, win_valid1, fd1);
        end
        q1.delete();
        run_scan(1'b0, 1'b0, ok, cyc);
        total++;
        if (!ok || q1.size() !== 12 || cyc !== 35) begin
            bad++; $display("FAIL rst_rescan got ok=%b count=%0d cyc=%0d want 1/12/35", ok, q1.size(), cyc);
        end
        if (q1.size() > 0) begin
            total++;
            if ({q1[0].x, q1[0].y} !== 20'd0) begin
                bad++; $display("FAIL rst_first got (%0d,%0d) want (0,0)", q1[0].x, q1[0].y);
            end
        end
    endtask

    task automatic test_start_while_busy;
        bit ok;
        int cyc;
        int badwin;
        q1.delete();
        fd1 = 0;
        run_scan(1'b0, 1'b1, ok, cyc);
        total++;
        if (!ok || cyc !== 35 || fd1 !== 1) begin
            bad++; $display("FAIL swb_done got ok=%b cyc=%0d fd=%0d want 1/35/1", ok, cyc, fd1);
        end
        badwin = 0;
        for (int i = 0; i < q1.size(); i++) begin
            if (q1[i].x !== 10'(i % 4) || q1[i].y !== 10'(i / 4) || q1[i].d !== exp_chunk(i % 4, i / 4)) badwin++;
        end
        total++;
        if (q1.size() !== 12 || badwin !== 0) begin
            bad++; $display("FAIL swb_seq got count=%0d badwin=%0d want 12/0", q1.size(), badwin);
        end
        total++;
        if (busy1 !== 1'b0) begin bad++; $display("FAIL swb_idle got busy=%b want 0", busy1); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        fd1        = 0;
        fd2        = 0;
        m1_en      = 1'b1;
        tag_c      = 80'h5A5A_0F0F_1234_5678_9ABC;
        garb_c     = {100{1'b1}};
        start1     = 1'b0;
        start2     = 1'b0;
        win_ready1 = 1'b1;
        win_ready2 = 1'b1;
        fb_data_ready1 = 1'b0;
        fb_data_ready2 = 1'b0;
        fb_data_chunk1 = '0;
        fb_data_chunk2 = '0;
        test_reset();
        test_full_scan();
        test_backpressure();
        test_xstep();
        test_timeout();
        test_reset_midscan();
        test_start_while_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fb_window_reader.md
FB_WINDOW_READER -- requirements
Module: fb_window_reader

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- WIDTH, 640, image width in pixels.
- HEIGHT, 480, image height in rows.
- X_STEP, 1, column increment between windows (1..WIDTH).
- TIMEOUT, 15, max cycles to wait on each framebuffer ready edge.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic is rising-edge.
- reset, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle request to scan one frame.
- busy, out, 1, high while any scan is in progress.
- frame_done, out, 1, one-cycle pulse after the last window handshake.
- err, out, 1, sticky timeout flag, cleared by the next accepted start.
- fb_x_pos, out, 10, framebuffer column address.
- fb_y_pos, out, 10, framebuffer centre-row address.
- fb_read, out, 1, framebuffer read request.
- fb_data_chunk, in, 100, framebuffer 5-row window; valid only while fb_data_ready is high.
- fb_data_ready, in, 1, framebuffer data-valid.
- win_data, out, 100, captured window.
- win_x, out, 10, column of the window.
- win_y, out, 10, row of the window.
- win_valid, out, 1, window available to the downstream block.
- win_ready, in, 1, downstream accepts the window.
- win_last, out, 1, high with win_valid on the final window of the frame.

Function
REQ-003 The block SHALL implement the states IDLE, ISSUE, RELEASE and OUTPUT.
REQ-004 In IDLE, start=1 SHALL load x=0, y=0, clear err, and enter ISSUE on the next edge; start outside IDLE SHALL be ignored.
REQ-005 In ISSUE, fb_read SHALL be 1, and fb_x_pos/fb_y_pos SHALL equal x/y and stay stable until RELEASE exits.
REQ-006 In ISSUE, the first edge sampling fb_data_ready=1 SHALL register fb_data_chunk into win_data and enter RELEASE; fb_data_chunk SHALL never be sampled while fb_data_ready=0.
REQ-007 In RELEASE, fb_read SHALL be 0.
- The first edge sampling fb_data_ready=0 SHALL enter OUTPUT.
REQ-008 In OUTPUT, win_valid SHALL be 1 and win_data/win_x/win_y/win_last SHALL be stable until the handshake edge.
- The handshake edge is the first edge with win_ready=1.
- win_valid SHALL NOT depend combinationally on win_ready.
REQ-009 On the OUTPUT handshake, if (x,y) is not the last window:
- x SHALL become x+X_STEP.
- If x+X_STEP >= WIDTH, x SHALL become 0 and y SHALL become y+1.
- The state SHALL return to ISSUE.
REQ-010 The last window SHALL be y=HEIGHT-1 and the largest x=k*X_STEP<WIDTH; its handshake SHALL pulse frame_done for exactly 1 cycle and enter IDLE.
REQ-011 x and y SHALL use 10-bit unsigned arithmetic, with the comparison done in 11 bits so it cannot wrap.
REQ-012 A per-state cycle counter SHALL clear on each state entry.
- If ISSUE or RELEASE reaches TIMEOUT cycles without the awaited edge, the block SHALL set err, drop fb_read and enter IDLE.
- A timeout SHALL NOT pulse frame_done.
REQ-013 busy SHALL be 1 in every state except IDLE.
REQ-014 Minimum throughput SHALL be 3 cycles per window (ISSUE, RELEASE, OUTPUT), given immediate ready edges and win_ready=1.

Reset
REQ-015 reset=0 SHALL immediately force:
- state IDLE;
- fb_read=0, win_valid=0, win_last=0, busy=0, frame_done=0, err=0;
- fb_x_pos=0, fb_y_pos=0, win_x=0, win_y=0, win_data=0.
REQ-016 Reset asserted mid-scan SHALL abandon the frame with no frame_done pulse; after reset release the block SHALL wait in IDLE for a new start.

Verification
REQ-017 Benches SHALL use WIDTH=4, HEIGHT=3, X_STEP=1 unless stated, and SHALL cover these scenarios:
- Full scan with a framebuffer model (ready 1 cycle after read, low 1 cycle after read drops) and win_ready=1 -> 12 windows in order (0,0),(1,0)..(3,2); win_last only on (3,2); one frame_done pulse; data matches the model.
- Backpressure with win_ready=0 for 5 cycles on window (2,1) -> win_valid, win_data, win_x=2, win_y=1 held constant; no new fb_read during the stall.
- X_STEP=3, WIDTH=4 -> windows at x=0,3 only; 6 windows total; last window (3,2).
- fb_data_ready never asserted -> err=1 exactly TIMEOUT cycles after ISSUE entry, fb_read=0, busy=0, no frame_done; the next start clears err.
- reset=0 during OUTPUT of window (1,1) -> all outputs 0 asynchronously; after release, start rescans from (0,0).
- start pulsed while busy -> ignored; the window sequence is unchanged.
